// File: rtl/nibble_pair_serial_tx.sv
// nibble_pair_serial_tx: serialises {b,a} nibble pairs as start|a|b|[parity]|stop.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b handshake in; tx line, busy, done out.
module nibble_pair_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] NEAR = BW'(CLKS_PER_BIT - 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bitcnt;
  logic [7:0]    sh;
  logic          par;
  logic          baud_end;

  assign baud_end = (baud == LAST);

  // tx is registered, so every transition loads the
  // line value of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud     <= '0;
      bitcnt   <= '0;
      sh       <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (in_valid && in_ready) begin
      state    <= S_START;
      baud     <= '0;
      bitcnt   <= '0;
      sh       <= {in_b, in_a};
      par      <= ^{in_b, in_a};
      tx       <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      if (state != S_IDLE)
        baud <= baud_end ? '0 : baud + 1'b1;
      unique case (state)
        S_START: begin
          if (baud_end) begin
            state  <= S_DATA;
            bitcnt <= '0;
            tx     <= sh[0];
          end
        end
        S_DATA: begin
          if (baud_end) begin
            if (bitcnt == 3'd7) begin
              if (PARITY_EN) begin
                state <= S_PARITY;
                tx    <= par;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              sh     <= sh >> 1;
              tx     <= sh[1];
              bitcnt <= bitcnt + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
        S_STOP: begin
          // Raise done/in_ready one edge early so both
          // are visible during the final stop cycle.
          if (baud == NEAR) begin
            done     <= 1'b1;
            in_ready <= 1'b1;
          end
          if (baud_end) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            tx    <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_pair_serial_tx.sv
// tb_nibble_pair_serial_tx: directed checks of frame shape,
// handshake, back-to-back, input stability and async reset.
module tb_nibble_pair_serial_tx;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic       v1 = 1'b0, v0 = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       rdy1, tx1, busy1, done1;
  logic       rdy0, tx0, busy0, done0;

  int n_cmp = 0;
  int n_err = 0;

  nibble_pair_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .tx(tx1), .busy(busy1), .done(done1)
  );

  nibble_pair_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .tx(tx0), .busy(busy0), .done(done0)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // {tx, busy, done, in_ready}
  function automatic logic [3:0] obs(input bit pe);
    return pe ? {tx1, busy1, done1, rdy1}
              : {tx0, busy0, done0, rdy0};
  endfunction

  task automatic chk(input string tag, input logic [3:0] o,
                     input logic [3:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic idle_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, obs(1'b1), 4'b1001);
      chk(tag, obs(1'b0), 4'b1001);
    end
  endtask

  // Called at a negedge; accept happens on the next posedge.
  task automatic frame(input logic [3:0] a, input logic [3:0] b,
                       input bit pe, input bit hold,
                       input string tag);
    logic [10:0] bits;
    int n;
    bits = pe ? {1'b1, ^{b, a}, b, a, 1'b0}
              : {1'b1, 1'b1, b, a, 1'b0};
    n = pe ? 44 : 40;
    in_a = a;
    in_b = b;
    if (pe) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk(tag, obs(pe),
          {bits[c / 4], 1'b1, (c == n - 1), (c == n - 1)});
      if (c == 0 && !hold) begin
        v1 = 1'b0;
        v0 = 1'b0;
      end
      if (c < n - 1) begin
        in_a = 4'($urandom);
        in_b = 4'($urandom);
      end
    end
  endtask

  task automatic mid_reset(input bit pe, input string tag);
    in_a = 4'b1110;
    in_b = 4'b0111;
    if (pe) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      v1 = 1'b0;
      v0 = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 chk(tag, obs(pe), 4'b1001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_chk(40, tag);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async1", obs(1'b1), 4'b1001);
    chk("rst_async0", obs(1'b0), 4'b1001);
    #5 rst_n = 1'b1;
    #3 clk_en = 1'b1;
    idle_chk(2, "idle0");

    frame(4'b1010, 4'b1010, 1'b1, 1'b0, "single");
    idle_chk(3, "idle1");
    frame(4'b1100, 4'b1011, 1'b1, 1'b0, "parity");
    idle_chk(2, "idle2");
    frame(4'b0110, 4'b1001, 1'b1, 1'b1, "b2b_first");
    frame(4'b1111, 4'b0000, 1'b1, 1'b0, "b2b_second");
    idle_chk(2, "idle3");
    frame(4'b0011, 4'b0101, 1'b0, 1'b0, "nopar");
    idle_chk(2, "idle4");

    mid_reset(1'b1, "rst_mid1");
    frame(4'b0001, 4'b0000, 1'b1, 1'b0, "after_rst1");
    idle_chk(2, "idle5");
    mid_reset(1'b0, "rst_mid0");
    frame(4'b0001, 4'b0000, 1'b0, 1'b0, "after_rst0");
    idle_chk(2, "idle6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
